xbus_feeder: RTL and testbench
==============================

# xbus_feeder

Upstream stage of the X-bus controller. Accepts a stream of input-feature-map pixels, buffers them in a small FIFO, and presents each pixel to the X bus with a column tag. Tags cycle modulo the effective kernel width and restart at every row boundary, so the tag allocator and the PE columns see a well-formed tag sequence. Runs entirely in the `clk` domain; the PE-side crossing happens further downstream.

## Interface

Parameters:
- `DATA_WIDTH`, 16, pixel width
- `NUM_COL`, 4, PE columns; tag width is `$clog2(NUM_COL)`
- `FIFO_DEPTH`, 8, buffer entries; must be a power of two and at least 2

Ports:
- `clk`  in  1  system clock; every flop is on its rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `flush`  in  1  synchronous clear of FIFO, counters and FSM; same effect as reset
- `kernel_size`  in  8  kernel width; sampled at row start
- `in_data`  in  DATA_WIDTH  pixel
- `in_last`  in  1  last pixel of the row
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  `!full`
- `out_data`  out  DATA_WIDTH  pixel to the X bus
- `out_tag`  out  `$clog2(NUM_COL)`  column tag
- `out_last`  out  1  last beat of the row
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  X-bus accept
- `row_done`  out  1  one-cycle pulse after the last beat of a row is accepted
- `busy`  out  1  FSM not in IDLE, or FIFO not empty
- `stall_cnt`  out  16  back-pressure counter (see Configuration)

## Operation

- **Push and pop.** A push happens on `in_valid && in_ready`. A pop happens on `out_valid && out_ready`. Each FIFO entry stores `{in_last, in_data}`.
- **Reset and flush values.** On `!rstn` or `flush` every output is 0: `in_ready` 0 during reset, `out_*` 0, `row_done` 0, `busy` 0, `stall_cnt` 0. The FIFO is emptied and the FSM returns to IDLE. Reset wins over flush.
- **IDLE.** Entered on reset or flush. When the FIFO is non-empty:
  - latch `k_eff = min(max(kernel_size,1), NUM_COL)`;
  - set `tag_cnt = 0`;
  - go to RUN.
- **RUN.** `out_valid = !empty` and `out_tag = tag_cnt`. On each pop:
  - if `out_last` is set, go to DONE;
  - otherwise `tag_cnt` advances to `tag_cnt + 1`, or to 0 when `tag_cnt == k_eff-1`.
- **DONE.** Lasts one cycle. `row_done = 1` and `out_valid = 0`. The next state is RUN if the FIFO is non-empty, else IDLE. Either way `k_eff` is re-latched and `tag_cnt` is set to 0.
- **Mid-row kernel changes.** A change of `kernel_size` inside a row is ignored until the next row.
- **Single-beat row** (`in_last` on the first pixel): tag 0, then DONE.
- **kernel_size = 0** is treated as 1, so every tag is 0.
- **kernel_size > NUM_COL** is clamped to `NUM_COL`.

## Timing

- **Latency.** A pixel pushed into an empty FIFO in cycle N appears on `out_*` no earlier than cycle N+2: one cycle to write the FIFO, one cycle for the IDLE→RUN transition. While the FSM is in RUN, a push into an empty FIFO appears in cycle N+1. There is no combinational bypass from `in_*` to `out_*`.
- **Throughput.** One beat per cycle. DONE costs one bubble per row.
- **Full FIFO.** `in_ready` is 0 even if a pop occurs in the same cycle; the freed slot is visible the next cycle.
- **Empty FIFO.** `out_valid` is 0, and `tag_cnt` holds.
- **Simultaneous push and pop** when not full and not empty: the occupancy count is unchanged.
- **Output stability.** `out_data`, `out_tag` and `out_last` stay stable while `out_valid && !out_ready`.
- **Pointer wrap.** Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra MSB.
- **Reset mid-row.** In-flight pixels are discarded, and the next beat out carries tag 0.

## Configuration

- **`XBUS_FEEDER_PERF_EN` defined:** `stall_cnt` increments every cycle with `out_valid && !out_ready`. It saturates at 16'hFFFF and is cleared by reset or flush.
- **Not defined:** `stall_cnt` is tied to 0 and its counter logic is not synthesized.

## Test plan

- **Basic row.** Reset, then `kernel_size=3`; push pixels 0x10..0x16 with `in_last` on 0x16 and `out_ready=1`. Required: tags 0,1,2,0,1,2,0; `out_last` only with 0x16; `row_done` pulses once, one cycle after that pop.
- **Clamping.** With `NUM_COL=4` and `kernel_size=5`, push 6 pixels. Required: tags 0,1,2,3,0,1. Repeat with `kernel_size=0`: all tags 0.
- **Back-pressure.** Hold `out_ready=0` and push 9 beats. Required: `in_ready` falls after 8 pushes; `out_*` stay stable. Release: all 9 pixels emerge in order. With the perf macro, `stall_cnt` equals the number of stalled cycles.
- **Mid-row kernel change.** Change `kernel_size` 3→2 in the middle of row 1. Required: row 1 keeps mod-3 tags; row 2 uses mod-2 tags starting at 0; one idle bubble between the rows.
- **Flush.** Assert `flush` for one cycle with 4 pixels buffered mid-row. Required: the next cycle has `busy=0` and `out_valid=0`; the next pushed pixel emerges with tag 0.
- **Reset during stall.** Apply `rstn=0` while stalled. Required: every output reads 0 on the next edge; streaming resumes correctly after `rstn=1`.

Source files
------------

// File: rtl/xbus_feeder.sv
// ============================================================================
// xbus_feeder: pixel FIFO plus column-tag sequencer feeding the X bus.
// Optional feature macro: XBUS_FEEDER_PERF_EN (back-pressure stall counter).
// Revision: 1.0
// ============================================================================
`default_nettype none

module xbus_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic [7:0]                 kernel_size,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(NUM_COL)-1:0] out_tag,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       row_done,
  output logic                       busy,
  output logic [15:0]                stall_cnt
);

  localparam int TW = $clog2(NUM_COL);
  localparam int KW = TW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [TW-1:0]         r_tag;
  logic [KW-1:0]         r_keff;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH:0]   w_head;
  logic [KW-1:0]         w_keff;

  // Extra pointer MSB separates the full case from the empty case.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_keff = KW'(1);
    if (kernel_size > 8'(NUM_COL)) begin
      w_keff = KW'(NUM_COL);
    end else if (kernel_size != 8'd0) begin
      w_keff = kernel_size[KW-1:0];
    end
  end

  assign in_ready  = rstn & ~flush & ~w_full;
  assign out_valid = (r_state == S_RUN) && !w_empty;
  assign out_data  = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & w_head[DATA_WIDTH];
  assign out_tag   = out_valid ? r_tag : '0;
  assign row_done  = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE) || !w_empty;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
      r_keff  <= KW'(1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_keff  <= w_keff;
            r_tag   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            if (w_head[DATA_WIDTH]) begin
              r_state <= S_DONE;
            end else if ({1'b0, r_tag} == r_keff - KW'(1)) begin
              r_tag <= '0;
            end else begin
              r_tag <= r_tag + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_keff  <= w_keff;
          r_tag   <= '0;
          r_state <= w_empty ? S_IDLE : S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef XBUS_FEEDER_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xbus_feeder.sv
// ============================================================================
// tb_xbus_feeder: randomized and directed stimulus against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xbus_feeder;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int FD = 8;
  localparam int TW = $clog2(NC);

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic [7:0]    kernel_size;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          row_done;
  logic          busy;
  logic [15:0]   stall_cnt;

  xbus_feeder #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .kernel_size(kernel_size),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .row_done(row_done), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: FIFO contents, row phase (0 idle, 1 streaming, 2 row end), latched
  // kernel width, beats already sent in the row, stalled cycles.
  logic [DW:0] mq [$];
  int          m_phase;
  int          m_k;
  int          m_idx;
  int          m_stall;
  bit          acc;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int keff(input int ks);
    return (ks == 0) ? 1 : ((ks > NC) ? NC : ks);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_phase = 0;
    m_k     = 1;
    m_idx   = 0;
    m_stall = 0;
  endtask

  task automatic step();
    bit          ev;
    bit          ir;
    bit          pop;
    bit          push;
    bit          ne;
    logic [DW:0] hd;
    #1;
    ev = (m_phase == 1) && (mq.size() > 0);
    hd = ev ? mq[0] : '0;
    ir = rstn && !flush && (mq.size() < FD);
    chk_val("out_valid", 32'(out_valid), 32'(ev));
    chk_val("out_data",  32'(out_data),  32'(hd[DW-1:0]));
    chk_val("out_last",  32'(out_last),  32'(hd[DW]));
    chk_val("out_tag",   32'(out_tag),   ev ? 32'(m_idx % m_k) : 32'd0);
    chk_val("in_ready",  32'(in_ready),  32'(ir));
    chk_val("row_done",  32'(row_done),  32'(m_phase == 2));
    chk_val("busy",      32'(busy),      32'((m_phase != 0) || (mq.size() > 0)));
    chk_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    acc = 1'b0;
    if (!rstn || flush) begin
      model_clear();
    end else begin
      pop  = ev && out_ready;
      push = in_valid && ir;
      ne   = mq.size() > 0;
`ifdef XBUS_FEEDER_PERF_EN
      if (ev && !out_ready && m_stall < 16'hFFFF) m_stall++;
`endif
      case (m_phase)
        0: if (ne) begin m_phase = 1; m_k = keff(int'(kernel_size)); m_idx = 0; end
        1: if (pop) begin
             if (hd[DW]) m_phase = 2;
             else m_idx++;
           end
        default: begin m_phase = ne ? 1 : 0; m_k = keff(int'(kernel_size)); m_idx = 0; end
      endcase
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({in_last, in_data});
      acc = push;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_row(input int n, input int base, input int rdy_pct,
                          input bit last_en, input int sw_at, input int sw_ks);
    int i   = 0;
    int cyc = 0;
    while (i < n && cyc < 200) begin
      if (i == sw_at) kernel_size = 8'(sw_ks);
      in_valid  = 1'b1;
      in_data   = DW'(base + i);
      in_last   = last_en && (i == n - 1);
      out_ready = ($urandom_range(99) < rdy_pct);
      step();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < n) chk_val("send_timeout", 32'(i), 32'(n));
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; flush = 1'b0; kernel_size = 8'd3;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    step(); step();
    rstn = 1'b1;
    idle(2);

    kernel_size = 8'd3;
    send_row(7, 'h10, 100, 1'b1, -1, 0);
    idle(5);

    kernel_size = 8'd5;
    send_row(6, 'h20, 100, 1'b1, -1, 0);
    idle(4);
    kernel_size = 8'd0;
    send_row(6, 'h30, 100, 1'b1, -1, 0);
    idle(4);

    kernel_size = 8'd2;
    out_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = DW'('h40 + cnt);
      in_last  = (cnt == 8);
      step();
      if (acc) cnt++;
    end
    chk_val("bp_accepted", 32'(cnt), 32'd8);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && cnt < 9; c++) begin
      in_valid = 1'b1;
      in_data  = DW'('h40 + cnt);
      in_last  = (cnt == 8);
      step();
      if (acc) cnt++;
    end
    chk_val("bp_drain", 32'(cnt), 32'd9);
    idle(12);

    kernel_size = 8'd3;
    send_row(6, 'h50, 100, 1'b1, 3, 2);
    send_row(5, 'h60, 100, 1'b1, -1, 0);
    idle(6);

    kernel_size = 8'd3;
    send_row(4, 'h70, 0, 1'b0, -1, 0);
    out_ready = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0; step();
    send_row(2, 'h78, 100, 1'b1, -1, 0);
    idle(4);

    send_row(5, 'h80, 0, 1'b0, -1, 0);
    out_ready = 1'b0;
    rstn = 1'b0; step(); step();
    rstn = 1'b1;
    send_row(3, 'h88, 100, 1'b1, -1, 0);
    idle(4);

    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = DW'($urandom);
        in_last  = ($urandom_range(4) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) kernel_size = 8'($urandom_range(6));
      flush = ($urandom_range(149) == 0);
      rstn  = ($urandom_range(299) != 0);
      step();
    end
    flush = 1'b0;
    rstn  = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
